// File: rtl/mtrisc_mem_arb_pkg.sv
// Shared types for the mtrisc RAM arbiter: read-owner tags, arbiter states, legal parameter ranges.
// Latency: none (types only); backpressure: none.
package mtrisc_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_D    = 2'd2
    } tag_e;

    typedef enum logic {
        ARB_DPRI   = 1'b0,
        ARB_FFORCE = 1'b1
    } arb_state_e;

    localparam int RD_LAT_MIN     = 1;
    localparam int RD_LAT_MAX     = 4;
    localparam int STARVE_MAX_MIN = 1;
    localparam int STARVE_MAX_MAX = 15;
    localparam int STARVE_W       = 4;

    function automatic bit params_legal(input int rd_lat, input int starve_max);
        return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX) &&
               (starve_max >= STARVE_MAX_MIN) && (starve_max <= STARVE_MAX_MAX);
    endfunction

endpackage

// File: rtl/mtrisc_mem_arb_if.sv
// Requester and RAM-port signals of the arbiter; slave = arbiter side, master = requesters/RAM side.
// Latency: n/a; backpressure: requesters hold req/addr/wdata until gnt.
interface mtrisc_mem_arb_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] ram_addr;
    logic [31:0] ram_in;
    logic        ram_wr;
    logic [31:0] ram_out;

    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, ram_out,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, ram_addr, ram_in, ram_wr
    );

    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, ram_out,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, ram_addr, ram_in, ram_wr
    );
endinterface

// File: rtl/mtrisc_mem_arb_rtag_pipe.sv
// Read-owner tag shift register, DEPTH stages; flush turns every IF tag into NONE at the edge.
// Latency: DEPTH cycles from in_tag to head_tag; backpressure: none, shifts every cycle.
module mtrisc_rtag_pipe
    import mtrisc_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rnt_p,
    input  logic flush,
    input  tag_e in_tag,
    output tag_e head_tag
);

    tag_e stage_q [DEPTH];
    tag_e stage_d [DEPTH];

    always_comb begin
        stage_d[0] = (flush && in_tag == TAG_IF) ? TAG_NONE : in_tag;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = (flush && stage_q[i-1] == TAG_IF) ? TAG_NONE : stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rnt_p) begin
        if (rnt_p) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= TAG_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign head_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/mtrisc_mem_arb.sv
// Single-port RAM arbiter: data requests win, fetch is forced after STARVE_MAX denied cycles.
// Latency: grant same cycle, RAM command next cycle, read data RD_LAT after that; backpressure: req held until gnt.
module mtrisc_mem_arb
    import mtrisc_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rnt_p,
    mtrisc_mem_arb_if.slave bus
);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [31:0]         ram_addr_q, ram_addr_d;
    logic [31:0]         ram_in_q, ram_in_d;
    logic                ram_wr_q, ram_wr_d;
    tag_e                cmd_tag_q, cmd_tag_d, head_tag;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         d_rdata_q, d_rdata_d;
    logic                if_gnt, d_gnt, if_acc, d_acc;
    logic                if_rvalid, d_rvalid;

    if (!params_legal(RD_LAT, STARVE_MAX)) begin : g_bad_params
        $error("mtrisc_mem_arb: RD_LAT or STARVE_MAX outside legal range");
    end

    // Grants are purely combinational; reset masks them so nothing is accepted while held.
    always_comb begin
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        starve_d = starve_q;
        state_d  = ARB_DPRI;
        if (!rnt_p) begin
            if (state_q == ARB_FFORCE) if_gnt = 1'b1;
            else if (bus.d_req)        d_gnt  = 1'b1;
            else if (bus.if_req)       if_gnt = 1'b1;
        end
        if_acc = bus.if_req & if_gnt;
        d_acc  = bus.d_req & d_gnt;
        if (if_gnt || !bus.if_req) starve_d = '0;
        else                       starve_d = starve_q + STARVE_W'(1);
        if (state_q == ARB_DPRI && starve_d == STARVE_W'(STARVE_MAX)) state_d = ARB_FFORCE;
    end

    // The tag rides with the RAM command so it enters the tag pipe aligned with the RAM access.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_in_d   = ram_in_q;
        ram_wr_d   = 1'b0;
        cmd_tag_d  = TAG_NONE;
        if (d_acc) begin
            ram_addr_d = bus.d_addr;
            ram_wr_d   = bus.d_we;
            if (bus.d_we) ram_in_d  = bus.d_wdata;
            else          cmd_tag_d = TAG_D;
        end else if (if_acc) begin
            ram_addr_d = bus.if_addr;
            if (!bus.if_flush) cmd_tag_d = TAG_IF;
        end
    end

    always_comb begin
        if_rvalid  = (head_tag == TAG_IF);
        d_rvalid   = (head_tag == TAG_D);
        if_rdata_d = if_rvalid ? bus.ram_out : if_rdata_q;
        d_rdata_d  = d_rvalid  ? bus.ram_out : d_rdata_q;
    end

    always_ff @(posedge clk or posedge rnt_p) begin
        if (rnt_p) begin
            state_q    <= ARB_DPRI;
            starve_q   <= '0;
            ram_addr_q <= '0;
            ram_in_q   <= '0;
            ram_wr_q   <= 1'b0;
            cmd_tag_q  <= TAG_NONE;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            ram_addr_q <= ram_addr_d;
            ram_in_q   <= ram_in_d;
            ram_wr_q   <= ram_wr_d;
            cmd_tag_q  <= cmd_tag_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    mtrisc_rtag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rtag_pipe (
        .clk      (clk),
        .rnt_p    (rnt_p),
        .flush    (bus.if_flush),
        .in_tag   (cmd_tag_q),
        .head_tag (head_tag)
    );

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rdata_d;
    assign bus.d_rdata   = d_rdata_d;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_in    = ram_in_q;
    assign bus.ram_wr    = ram_wr_q;

endmodule

// File: doc/mtrisc_mem_arb.md
# mtrisc_mem_arb

Single-port memory arbiter for the mtrisc core. It shares the one RAM port (ram_addr/ram_in/ram_out/ram_wr) between two requesters:
- the instruction-fetch requester (pc_out path);
- the data requester (STR/PUSH writes, POP reads).

Data accesses have priority. A starvation counter guarantees fetch progress. Read responses are routed back to their owner through a tag pipeline that matches the RAM read latency.

## Interface
- RD_LAT, 1, cycles from RAM command registered to ram_out valid; legal 1..4
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced; legal 1..15
- clk  in  1  clock, all logic on rising edge
- rnt_p  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  32  fetch address, word aligned
- if_flush  in  1  discard all in-flight fetch responses (branch taken)
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  32  data read data
- ram_addr  out  32  registered RAM address
- ram_in  out  32  registered RAM write data
- ram_wr  out  1  registered RAM write strobe
- ram_out  in  32  RAM read data

## Operation
**Grants**
- if_gnt and d_gnt are combinational from the requests and the arbiter state. At most one grant per cycle.
- A request is accepted in a cycle where req=1 and gnt=1. The requester holds req, addr and wdata stable until it sees gnt.

**Arbiter FSM**
- DPRI (reset state):
  - d_req=1 → d_gnt=1.
  - d_req=0 and if_req=1 → if_gnt=1.
- starve counter (4 bits):
  - Increments each cycle with if_req=1 and if_gnt=0.
  - Clears on if_gnt=1 or on if_req=0.
  - When it reaches STARVE_MAX, the FSM goes to FFORCE.
- FFORCE: if_gnt=1 unconditionally; d_gnt=0. Next state is DPRI and the counter clears.

**RAM command**
- At the rising edge of an accepted cycle, ram_addr, ram_wr and ram_in are loaded:
  - ram_wr = d_we for data, 0 for fetch.
  - ram_in = d_wdata for data writes; held otherwise.
- In a cycle with no grant, ram_wr is loaded 0 and ram_addr/ram_in hold their values.

**Tag pipeline** (depth RD_LAT)
- Tag values: NONE, IF, D.
- Each accepted read pushes IF or D. Writes and idle cycles push NONE.
- At the head of the pipeline:
  - IF → if_rvalid=1.
  - D → d_rvalid=1.
  - rdata for the owner = ram_out (combinational, valid only while rvalid=1).
- Non-owner rdata outputs are held at their last value.

**Flush**
- if_flush=1 converts every IF tag in the pipeline to NONE at the edge.
- A fetch granted in the same cycle as if_flush is also discarded.
- D tags are unaffected.

**Simultaneous events**
- Both requests in DPRI with counter < STARVE_MAX → data wins.
- Both requests in FFORCE → fetch wins.

**Reset** (any time, including mid-access)
- Outputs: ram_addr=0, ram_in=0, ram_wr=0, all gnt/rvalid=0, rdata=0.
- Tag pipeline all NONE, FSM in DPRI, counter 0.
- No rvalid is produced for any access issued before reset.

## Timing
- Grant: same cycle as req (combinational).
- RAM command: visible in the cycle after grant (T+1).
- Read response: rvalid at T+1+RD_LAT. With RD_LAT=1, rvalid is at T+2.
- Throughput: one access per cycle, back-to-back; reads and writes may interleave freely.
- Worst-case fetch wait with continuous d_req: STARVE_MAX cycles, then granted.

## Structure
- Shared package mtrisc_pkg:
  - owner tag typedef (TAG_NONE, TAG_IF, TAG_D);
  - arbiter state typedef (ARB_DPRI, ARB_FFORCE);
  - RD_LAT/STARVE_MAX legal-range constants.
- Sub-module mtrisc_rtag_pipe: RD_LAT-deep tag shift register with flush-clear of IF tags and async reset. The arbiter FSM and command registers stay in mtrisc_mem_arb.

## Test plan
- Fetch only, RD_LAT=1: if_req with if_addr=0x0,0x4,0x8 on consecutive cycles → if_gnt=1 each cycle, ram_addr 0x0/0x4/0x8 at T+1..T+3, if_rvalid T+2..T+4 with matching ram_out data.
- Simultaneous requests: if_req=d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → d_gnt=1, if_gnt=0; next cycle ram_wr=1, ram_addr=0x100, ram_in=0xDEADBEEF; no rvalid.
- Starvation, STARVE_MAX=4: d_req held high plus if_req=1 → d_gnt for 4 cycles, if_gnt on the 5th cycle, then d_gnt resumes.
- Flush, RD_LAT=3: two fetch reads granted, then if_flush=1 → neither if_rvalid ever asserts; a D read issued between them still produces d_rvalid at T+4.
- Reset mid-read, RD_LAT=2: assert rnt_p one cycle after a granted data read → d_rvalid never asserts; ram_wr=0, ram_addr=0 immediately; FSM back in DPRI.
- Data read after write, RD_LAT=2: write 0x12345678 to 0x40, then read 0x40 → d_rvalid at T+3 of the read, d_rdata=0x12345678.
